// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared states, funct3 encodings and access-size helper for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane shifter: store byte mask/data placement, load extract and extend
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [63:0] rword,
    output logic [7:0]  mask,
    output logic [63:0] wdata64,
    output logic [31:0] rdata
);

    logic [7:0]  size_mask;
    logic [31:0] shifted;

    always_comb begin
        size_mask = (8'd1 << size_of(funct3)) - 8'd1;
        mask      = size_mask << offset;
        wdata64   = {32'd0, wdata} << {offset, 3'b000};
        // Only the low word matters after the shift: the access never exceeds four bytes.
        shifted   = 32'(rword >> {offset, 3'b000});
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = shifted;
            F3_BU:   rdata = {24'd0, shifted[7:0]};
            F3_HU:   rdata = {16'd0, shifted[15:0]};
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit in front of dmem; LSU_MISALIGNED_EN enables word-crossing splits
module lsu
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-3:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_byteen,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_t       state, next;
    logic             r_we, r_err;
    logic [2:0]       r_f3;
    logic [WIDTH-1:0] r_addr, r_wdata, lo_word, hi_word;
    logic [7:0]       mask;
    logic [63:0]      wdata64;
    logic [31:0]      ld_data;
    logic             accept, acc_illegal, acc_err;
    logic [2:0]       acc_size;

    assign req_ready   = (state == IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    assign acc_size    = size_of(req_funct3);
    assign acc_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7)
                       || (req_we && req_funct3[2]);

`ifdef LSU_MISALIGNED_EN
    logic acc_cross, r_cross;
    assign acc_cross = ({2'b00, req_addr[1:0]} + {1'b0, acc_size}) > 4'd4;
    assign acc_err   = acc_illegal;
`else
    logic acc_misal;
    // Any access not naturally aligned is rejected; this also covers every word-crossing case.
    assign acc_misal = ((acc_size == 3'd2) && req_addr[0]) || ((acc_size == 3'd4) && (req_addr[1:0] != 2'b00));
    assign acc_err   = acc_illegal || acc_misal;
`endif

    lsu_align u_align (
        .funct3  (r_f3),
        .offset  (r_addr[1:0]),
        .wdata   (r_wdata),
        .rword   ({hi_word, lo_word}),
        .mask    (mask),
        .wdata64 (wdata64),
        .rdata   (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            lo_word <= '0;
            hi_word <= '0;
`ifdef LSU_MISALIGNED_EN
            r_cross <= 1'b0;
`endif
        end else begin
            state <= next;
            if (accept) begin
                r_we    <= req_we;
                r_err   <= acc_err;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
`ifdef LSU_MISALIGNED_EN
                r_cross <= acc_cross;
`endif
            end
            if (state == LO) lo_word <= mem_rdata;
            if (state == HI) hi_word <= mem_rdata;
        end
    end

    always_comb begin
        next       = state;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_byteen = 4'd0;
        case (state)
            IDLE: if (accept) next = acc_err ? RESP : LO;
            LO: begin
                mem_read   = !r_we;
                mem_write  = r_we;
                mem_addr   = r_addr[WIDTH-1:2];
                mem_byteen = mask[3:0];
                mem_wdata  = r_we ? wdata64[31:0] : '0;
`ifdef LSU_MISALIGNED_EN
                next = r_cross ? HI : RESP;
`else
                next = RESP;
`endif
            end
            HI: begin
                mem_read   = !r_we;
                mem_write  = r_we;
                mem_addr   = r_addr[WIDTH-1:2] + (WIDTH-2)'(1);
                mem_byteen = mask[7:4];
                mem_wdata  = r_we ? wdata64[63:32] : '0;
                next       = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = (r_err || r_we) ? '0 : ld_data;
                next       = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu with a byte-enabled word memory model
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_byteen;

    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    int          r_lat, r_strobes;
    logic [31:0] r_data;
    logic        r_err;
    logic        s1_rd, s1_wr, s2_rd, s2_wr;
    logic [29:0] s1_addr, s2_addr;
    logic [3:0]  s1_be, s2_be;
    logic [31:0] s1_wd, s2_wd;

    always #5 clk = ~clk;

    lsu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteen[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        r_strobes = 0;
        s1_rd = mem_read; s1_wr = mem_write; s1_addr = mem_addr; s1_be = mem_byteen; s1_wd = mem_wdata;
        s2_rd = 1'b0; s2_wr = 1'b0; s2_addr = '0; s2_be = '0; s2_wd = '0;
        if (mem_read || mem_write) r_strobes++;
        while (!resp_valid && n < 8) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                s2_rd = mem_read; s2_wr = mem_write; s2_addr = mem_addr; s2_be = mem_byteen; s2_wd = mem_wdata;
            end
            if (mem_read || mem_write) r_strobes++;
        end
        r_lat  = n;
        r_data = resp_rdata;
        r_err  = resp_err;
    endtask

    initial begin
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst_addr", {2'b00, mem_addr}, 32'd0);
        check("rst_byteen", {28'd0, mem_byteen}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        run(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        check("sw_lo_write", {30'd0, s1_rd, s1_wr}, 32'd1);
        check("sw_lo_addr", {2'b00, s1_addr}, 32'h40);
        check("sw_lo_be", {28'd0, s1_be}, 32'hF);
        check("sw_lo_wd", s1_wd, 32'hDEADBEEF);
        check("sw_lat", r_lat, 2);
        check("sw_resp", r_data, 32'd0);
        check("sw_err", {31'd0, r_err}, 32'd0);

        run(1'b0, 3'd2, 32'h100, 32'd0);
        check("lw_lo_read", {30'd0, s1_rd, s1_wr}, 32'd2);
        check("lw_lo_addr", {2'b00, s1_addr}, 32'h40);
        check("lw_lo_be", {28'd0, s1_be}, 32'hF);
        check("lw_lat", r_lat, 2);
        check("lw_data", r_data, 32'hDEADBEEF);
        check("lw_err", {31'd0, r_err}, 32'd0);

        run(1'b1, 3'd0, 32'h103, 32'h000000A5);
        check("sb_be", {28'd0, s1_be}, 32'h8);
        check("sb_wd", s1_wd, 32'hA5000000);
        run(1'b0, 3'd0, 32'h103, 32'd0);
        check("lb_data", r_data, 32'hFFFFFFA5);
        run(1'b0, 3'd4, 32'h103, 32'd0);
        check("lbu_data", r_data, 32'h000000A5);

        run(1'b1, 3'd1, 32'h102, 32'h00001234);
        check("sh_be", {28'd0, s1_be}, 32'hC);
        check("sh_wd", s1_wd, 32'h12340000);
        run(1'b0, 3'd1, 32'h102, 32'd0);
        check("lh_be", {28'd0, s1_be}, 32'hC);
        check("lh_data", r_data, 32'h00001234);
        run(1'b1, 3'd1, 32'h102, 32'h00008001);
        run(1'b0, 3'd5, 32'h102, 32'd0);
        check("lhu_data", r_data, 32'h00008001);
        run(1'b0, 3'd1, 32'h102, 32'd0);
        check("lh_neg_data", r_data, 32'hFFFF8001);
        run(1'b0, 3'd2, 32'h100, 32'd0);
        check("word_merge", r_data, 32'h8001BEEF);

        run(1'b1, 3'd2, 32'h0FC, 32'h11223344);
        run(1'b1, 3'd2, 32'h100, 32'h55667788);
        run(1'b0, 3'd2, 32'h0FE, 32'd0);
`ifdef LSU_MISALIGNED_EN
        check("split_lo_addr", {2'b00, s1_addr}, 32'h3F);
        check("split_lo_be", {28'd0, s1_be}, 32'hC);
        check("split_hi_read", {31'd0, s2_rd}, 32'd1);
        check("split_hi_addr", {2'b00, s2_addr}, 32'h40);
        check("split_hi_be", {28'd0, s2_be}, 32'h3);
        check("split_lat", r_lat, 3);
        check("split_data", r_data, 32'h77881122);
        check("split_err", {31'd0, r_err}, 32'd0);
        run(1'b0, 3'd2, 32'hFFFFFFFE, 32'd0);
        check("wrap_hi_addr", {2'b00, s2_addr}, 32'h0);
        check("wrap_lat", r_lat, 3);
`else
        check("misal_lw_lat", r_lat, 1);
        check("misal_lw_err", {31'd0, r_err}, 32'd1);
        check("misal_lw_strobes", r_strobes, 0);
        check("misal_lw_data", r_data, 32'd0);
        run(1'b0, 3'd1, 32'h101, 32'd0);
        check("misal_lh_err", {31'd0, r_err}, 32'd1);
        check("misal_lh_lat", r_lat, 1);
`endif

        run(1'b0, 3'd3, 32'h100, 32'd0);
        check("f3_3_lat", r_lat, 1);
        check("f3_3_err", {31'd0, r_err}, 32'd1);
        check("f3_3_strobes", r_strobes, 0);
        run(1'b1, 3'd4, 32'h100, 32'h12345678);
        check("f3_4st_lat", r_lat, 1);
        check("f3_4st_err", {31'd0, r_err}, 32'd1);
        check("f3_4st_strobes", r_strobes, 0);
        run(1'b0, 3'd2, 32'h100, 32'd0);
        check("no_illegal_write", r_data, 32'h55667788);

`ifdef LSU_MISALIGNED_EN
        run(1'b1, 3'd2, 32'h1FC, 32'd0);
        run(1'b1, 3'd2, 32'h200, 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h1FE; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_hi_state", {2'b00, mem_addr}, 32'h80);
`else
        run(1'b1, 3'd2, 32'h200, 32'd0);
        run(1'b1, 3'd2, 32'h204, 32'h0BADCAFE);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_lo_state", {31'd0, mem_write}, 32'd1);
`endif
        #1 rst = 1'b1;
        #1;
        check("abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("abort_byteen", {28'd0, mem_byteen}, 32'd0);
        check("abort_addr", {2'b00, mem_addr}, 32'd0);
        check("abort_wdata", mem_wdata, 32'd0);
        check("abort_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        check("abort_resp_hold", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
`ifdef LSU_MISALIGNED_EN
        run(1'b0, 3'd2, 32'h1FC, 32'd0);
        check("abort_lo_kept", r_data, 32'hF00D0000);
        run(1'b0, 3'd2, 32'h200, 32'd0);
        check("abort_hi_skipped", r_data, 32'd0);
        check("abort_next_lat", r_lat, 2);
`else
        run(1'b0, 3'd2, 32'h200, 32'd0);
        check("abort_no_write", r_data, 32'd0);
        run(1'b0, 3'd2, 32'h204, 32'd0);
        check("abort_next_data", r_data, 32'h0BADCAFE);
        check("abort_next_lat", r_lat, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly upstream of the data memory.
- Takes byte-addressed RV32I load/store requests from the execute stage and issues word-aligned accesses to the data memory: 30-bit word address, 4-bit byte enable, lane-shifted store data.
- Extracts and sign/zero-extends load data, then returns a registered response.
- Misaligned accesses are handled according to the optional feature below.

Parameters:
- WIDTH, 32, datapath/address width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  LSU can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu.
- req_addr  input  WIDTH  byte address.
- req_wdata  input  WIDTH  store data, right-justified.
- resp_valid  output  1  one-cycle pulse: request finished.
- resp_rdata  output  WIDTH  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; illegal funct3 or rejected misaligned access.
- mem_read  output  1  to dmem.
- mem_write  output  1  to dmem.
- mem_addr  output  WIDTH-2  word address to dmem.
- mem_wdata  output  WIDTH  lane-aligned store data.
- mem_byteen  output  4  byte enables.
- mem_rdata  input  WIDTH  dmem read word; combinational from mem_addr.

Behaviour:
- Reset: clk/rst only; asynchronous active-high. State goes to IDLE. resp_valid, resp_err, mem_read, mem_write = 0; mem_byteen = 0; mem_addr, mem_wdata, resp_rdata = 0; req_ready = 1 once rst deasserts.
- FSM states:
  - IDLE: req_ready = 1; no mem strobes.
  - LO: first word access.
  - HI: second word access, misaligned split only.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Accept: req_valid && req_ready at an edge latches the request and moves to LO, or to RESP for an error.
- Size: 1, 2 or 4 bytes from funct3[1:0].
- Offset: addr[1:0].
- Cross: offset + size > 4.
- Lane math:
  - mask64 = ((1<<size)-1) << offset.
  - data64 = zero-extended wdata << (8*offset).
  - LO uses mem_addr = addr[31:2], byteen = mask64[3:0], wdata = data64[31:0].
  - HI uses mem_addr = addr[31:2]+1 (wraps 0x3FFFFFFF -> 0), byteen = mask64[7:4], wdata = data64[63:32].
- Strobes: mem_read (load) or mem_write (store) is high only in LO/HI. byteen is driven for loads too.
- Load capture: mem_rdata is sampled into lo_word at the end of LO and into hi_word at the end of HI. Load result = ({hi_word, lo_word} >> 8*offset), truncated to size, then sign-extended (funct3 0, 1) or zero-extended (4, 5).
- Aligned latency: accept T, LO T+1, resp_valid T+2.
- Split latency: accept T, LO T+1, HI T+2, resp_valid T+3.
- Throughput: next accept is possible the cycle after RESP, i.e. one request in flight.
- Illegal funct3 (3, 6, 7; or 4, 5 with req_we = 1): no memory access; RESP with resp_err = 1 at T+1.
- Stores: resp_valid is an acknowledge; resp_rdata = 0.
- Reset mid-operation: FSM aborts to IDLE and no response is produced. A LO store write already committed at a prior edge remains committed; the HI half is not written.
- req inputs are ignored while req_ready = 0.

Optional Feature:
- Macro: LSU_MISALIGNED_EN.
- Defined: crossing accesses split LO -> HI as above; resp_err only for illegal funct3.
- Undefined: no HI state. Crossing accesses also treat intra-word misalignment (lh at offset 1 or 3, lw with offset != 0) as errors: no mem access, RESP with resp_err = 1 at T+1, resp_rdata = 0.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum lsu_state_t {IDLE, LO, HI, RESP};
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - function size_of(funct3).
- One sub-module, lsu_align: combinational lane shifter producing mask64/data64 for stores and extract/extend for loads. The FSM stays in lsu.

Test Plan:
- sw addr 0x100 wdata 0xDEADBEEF, then lw 0x100 -> LO at T+1 with mem_addr 0x40, byteen 0xF; load resp_rdata 0xDEADBEEF at T+2, err 0.
- sb 0x103 wdata 0x000000A5 -> byteen 0x8, mem_wdata 0xA5000000; then lb 0x103 -> 0xFFFFFFA5 and lbu 0x103 -> 0x000000A5.
- sh 0x102 0x1234, then lh 0x102 -> byteen 0xC, resp 0x00001234; lhu after sh 0x8001 -> 0x00008001, lh -> 0xFFFF8001.
- With LSU_MISALIGNED_EN, lw 0x0FE over words 0x3F = 0x11223344 and 0x40 = 0x55667788 -> LO byteen 0xC, HI byteen 0x3 at mem_addr 0x40, resp 0x77881122 at T+3. Without the macro -> resp_err 1 at T+1 and no mem strobes.
- funct3 3 load and funct3 4 store -> resp_err 1 at T+1, mem_read/mem_write never asserted.
- Assert rst during HI of a split sw -> outputs zero immediately, no HI write, no resp_valid; req_ready 1 after release and the next lw completes normally.
